nova_bs_feeder: RTL and testbench

NOVA_BS_FEEDER -- requirements
Module: nova_bs_feeder

---
 rtl/nova_bs_feeder.sv | 168 ++++++++++++++++
 tb/tb_nova_bs_feeder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nova_bs_feeder.sv
// nova_bs_feeder: ring buffer feeding network bitstream words to the decoder.
// Define NOVA_BS_FEEDER_STATS_EN to add stall_cycles/words_in counters.
module nova_bs_feeder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [15:0]       in_word,
  input  logic              in_valid,
  output logic              in_stop,
  input  logic              bs_ren_n,
  input  logic [ADDR_W-1:0] bs_addr,
  output logic [15:0]       bs_data,
  output logic              bs_valid,
  output logic              dec_stop,
`ifdef NOVA_BS_FEEDER_STATS_EN
  output logic              err_backref,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       words_in
`else
  output logic              err_backref
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic {
    IDLE,
    WAIT_FILL
  } state_t;

  state_t state, state_nx;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] lat_addr;
  logic [CW-1:0]     count;
  logic              hit_q;

  logic [ADDR_W-1:0] d_req;
  logic [ADDR_W-1:0] d_lat;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] base_nx;
  logic [ADDR_W-1:0] wr_nx;
  logic [CW-1:0]     count_nx;
  logic              req_hit;
  logic              req_back;
  logic              lat_hit;
  logic              accept;
  logic              serve;
  logic              serve_err;
  logic              lat_set;

  assign in_stop  = (count == CW'(DEPTH));
  assign accept   = in_valid && !in_stop && !flush;
  assign dec_stop = (state == WAIT_FILL);

  assign d_req    = bs_addr - base;
  assign d_lat    = lat_addr - base;
  assign req_hit  = d_req < ADDR_W'(count);
  assign req_back = d_req[ADDR_W-1];
  assign lat_hit  = d_lat < ADDR_W'(count);

  always_comb begin
    state_nx  = state;
    serve     = 1'b0;
    serve_err = 1'b0;
    lat_set   = 1'b0;
    rd_addr   = bs_addr;
    unique case (state)
      IDLE: begin
        if (!bs_ren_n) begin
          unique case (1'b1)
            req_hit:  serve = 1'b1;
            req_back: serve_err = 1'b1;
            default: begin
              lat_set  = 1'b1;
              state_nx = WAIT_FILL;
            end
          endcase
        end
      end
      WAIT_FILL: begin
        rd_addr = lat_addr;
        if (hit_q) begin
          serve    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A serve frees space in the same cycle an accept consumes it.
  assign base_nx  = serve ? rd_addr : base;
  assign wr_nx    = wr_addr + ADDR_W'(accept);
  assign count_nx = CW'(wr_nx - base_nx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wr_addr     <= '0;
      base        <= '0;
      count       <= '0;
      lat_addr    <= '0;
      hit_q       <= 1'b0;
      bs_valid    <= 1'b0;
      bs_data     <= '0;
      err_backref <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      wr_addr     <= '0;
      base        <= '0;
      count       <= '0;
      hit_q       <= 1'b0;
      bs_valid    <= 1'b0;
      err_backref <= 1'b0;
    end else begin
      state    <= state_nx;
      wr_addr  <= wr_nx;
      base     <= base_nx;
      count    <= count_nx;
      hit_q    <= (state == WAIT_FILL) && lat_hit;
      bs_valid <= serve || serve_err;
      if (lat_set) begin
        lat_addr <= bs_addr;
      end
      if (serve) begin
        bs_data <= mem[rd_addr[DEPTH_LOG2-1:0]];
      end else if (serve_err) begin
        bs_data <= '0;
      end
      if (serve_err) begin
        err_backref <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_addr[DEPTH_LOG2-1:0]] <= in_word;
    end
  end

`ifdef NOVA_BS_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      words_in     <= '0;
    end else if (flush) begin
      stall_cycles <= '0;
      words_in     <= '0;
    end else begin
      if (dec_stop && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (accept && words_in != '1) begin
        words_in <= words_in + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nova_bs_feeder.sv
// tb_nova_bs_feeder: scoreboard bench for nova_bs_feeder.
// Address width is reduced to 10 bits so the wrap case stays short.
module tb_nova_bs_feeder;

  localparam int AW    = 10;
  localparam int DL    = 6;
  localparam int DEPTH = 64;
  localparam int M     = (1 << AW) - 1;
  localparam int HALF  = 1 << (AW - 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic [15:0]   in_word;
  logic          in_valid;
  logic          in_stop;
  logic          bs_ren_n;
  logic [AW-1:0] bs_addr;
  logic [15:0]   bs_data;
  logic          bs_valid;
  logic          dec_stop;
  logic          err_backref;
`ifdef NOVA_BS_FEEDER_STATS_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   words_in;
`endif

  int errs = 0;
  int checks = 0;
  int nvalid = 0;
  int nv0;
  logic [15:0] exp_q[$];
  logic [15:0] ref_mem [1 << AW];
  int m_wr;
  int m_base;
  bit m_wait;

  always #5 clk = ~clk;

  nova_bs_feeder #(
    .DEPTH_LOG2(DL),
    .ADDR_W    (AW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_word     (in_word),
    .in_valid    (in_valid),
    .in_stop     (in_stop),
    .bs_ren_n    (bs_ren_n),
    .bs_addr     (bs_addr),
    .bs_data     (bs_data),
    .bs_valid    (bs_valid),
    .dec_stop    (dec_stop),
`ifdef NOVA_BS_FEEDER_STATS_EN
    .err_backref (err_backref),
    .stall_cycles(stall_cycles),
    .words_in    (words_in)
`else
    .err_backref (err_backref)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bs_valid) begin
      nvalid++;
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(bs_valid), 0);
      end else begin
        check("bs_data", 32'(bs_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // One clock: drive inputs, predict, then check occupancy after the edge.
  task automatic step(input bit v, input logic [15:0] w,
                      input bit rd, input int a);
    int d;
    int cnt;
    bit acc;
    cnt = (m_wr - m_base) & M;
    acc = v && (cnt != DEPTH);
    in_valid = v;
    in_word  = w;
    bs_ren_n = !rd;
    bs_addr  = AW'(a);
    if (rd && !m_wait) begin
      d = (a - m_base) & M;
      if (d < cnt) begin
        exp_q.push_back(ref_mem[a & M]);
        m_base = a & M;
      end else if (d >= HALF) begin
        exp_q.push_back(16'h0000);
      end else begin
        m_wait = 1'b1;
      end
    end
    if (acc) begin
      ref_mem[m_wr] = w;
      m_wr = (m_wr + 1) & M;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bs_ren_n = 1'b1;
    cnt = (m_wr - m_base) & M;
    check("in_stop", 32'(in_stop), 32'(cnt == DEPTH));
    check("count", 32'(dut.count), 32'(cnt));
  endtask

  task automatic do_flush();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_word  = 16'hDEAD;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    m_wr   = 0;
    m_base = 0;
    m_wait = 1'b0;
    check("flush_wr", 32'(dut.wr_addr), 0);
    check("flush_base", 32'(dut.base), 0);
    check("flush_count", 32'(dut.count), 0);
    check("flush_valid", 32'(bs_valid), 0);
    check("flush_stop", 32'(dec_stop), 0);
    check("flush_err", 32'(err_backref), 0);
    check("flush_in_stop", 32'(in_stop), 0);
`ifdef NOVA_BS_FEEDER_STATS_EN
    check("flush_stall", stall_cycles, 0);
    check("flush_words", words_in, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_word  = '0;
    bs_ren_n = 1'b1;
    bs_addr  = '0;
    m_wr     = 0;
    m_base   = 0;
    m_wait   = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_valid", 32'(bs_valid), 0);
    check("rst_data", 32'(bs_data), 0);
    check("rst_dec_stop", 32'(dec_stop), 0);
    check("rst_err", 32'(err_backref), 0);
    check("rst_in_stop", 32'(in_stop), 0);
    check("rst_count", 32'(dut.count), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // simple hit
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h1000 + i), 1'b0, 0);
    step(1'b0, 16'h0, 1'b1, 2);
    check("hit_valid", 32'(bs_valid), 1);
    check("hit_data", 32'(bs_data), 32'h1002);
    check("hit_base", 32'(dut.base), 2);
    check("hit_count", 32'(dut.count), 2);
    step(1'b0, 16'h0, 1'b0, 0);
    check("hit_pulse", 32'(bs_valid), 0);
    check("hold_data", 32'(bs_data), 32'h1002);

    // miss then fill
    do_flush();
    step(1'b0, 16'h0, 1'b1, 0);
    check("miss_stop", 32'(dec_stop), 1);
    check("miss_valid", 32'(bs_valid), 0);
    step(1'b0, 16'h0, 1'b1, 0);
    check("wait_ignore", 32'(bs_valid), 0);
    step(1'b1, 16'hABCD, 1'b0, 0);
    exp_q.push_back(16'hABCD);
    check("fill_e0_valid", 32'(bs_valid), 0);
    check("fill_e0_stop", 32'(dec_stop), 1);
    step(1'b0, 16'h0, 1'b0, 0);
    check("fill_e1_valid", 32'(bs_valid), 0);
    check("fill_e1_stop", 32'(dec_stop), 1);
    step(1'b0, 16'h0, 1'b0, 0);
    check("fill_e2_valid", 32'(bs_valid), 1);
    check("fill_e2_data", 32'(bs_data), 32'hABCD);
    check("fill_e2_stop", 32'(dec_stop), 0);
    m_wait = 1'b0;
    m_base = 0;
`ifdef NOVA_BS_FEEDER_STATS_EN
    check("stall_cnt", stall_cycles, 4);
`endif

    // full ring back-pressure
    do_flush();
    for (int i = 0; i < 64; i++) step(1'b1, 16'(16'h2000 + i), 1'b0, 0);
    check("full_stop", 32'(in_stop), 1);
    step(1'b1, 16'h2040, 1'b0, 0);
    check("full_hold", 32'(dut.wr_addr), 64);
    step(1'b1, 16'h2040, 1'b1, 10);
    check("free_stop", 32'(in_stop), 0);
    check("free_data", 32'(bs_data), 32'h200A);
    step(1'b1, 16'h2040, 1'b0, 0);
    check("w65_wr", 32'(dut.wr_addr), 65);
`ifdef NOVA_BS_FEEDER_STATS_EN
    check("words_cnt", words_in, 65);
`endif

    // address wrap
    do_flush();
    for (int i = 0; i < 'h3FE; i++) step(1'b1, 16'(i), i > 0, i - 1);
    check("pre_wr", 32'(dut.wr_addr), 'h3FE);
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'hC000 + i), 1'b0, 0);
    check("wrap_wr", 32'(dut.wr_addr), 2);
    step(1'b0, 16'h0, 1'b1, 1);
    check("wrap_valid", 32'(bs_valid), 1);
    check("wrap_data", 32'(bs_data), 32'hC003);

    // backward reference
    do_flush();
    for (int i = 0; i < 24; i++) step(1'b1, 16'(16'h3000 + i), 1'b0, 0);
    step(1'b0, 16'h0, 1'b1, 20);
    step(1'b0, 16'h0, 1'b1, 5);
    check("back_err", 32'(err_backref), 1);
    check("back_valid", 32'(bs_valid), 1);
    check("back_data", 32'(bs_data), 0);
    check("back_base", 32'(dut.base), 20);
    step(1'b0, 16'h0, 1'b0, 0);
    check("back_sticky", 32'(err_backref), 1);
    step(1'b0, 16'h0, 1'b1, 100);
    check("back_miss_stop", 32'(dec_stop), 1);
    do_flush();

    // reset while waiting
    step(1'b0, 16'h0, 1'b1, 3);
    step(1'b0, 16'h0, 1'b0, 0);
    check("rw_stop", 32'(dec_stop), 1);
    #3 reset_n = 1'b0;
    #1;
    check("rw_async_stop", 32'(dec_stop), 0);
    check("rw_async_valid", 32'(bs_valid), 0);
    check("rw_async_count", 32'(dut.count), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    m_wr   = 0;
    m_base = 0;
    m_wait = 1'b0;
    nv0    = nvalid;
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h4000 + i), 1'b0, 0);
    repeat (4) step(1'b0, 16'h0, 1'b0, 0);
    check("rw_no_valid", 32'(nvalid - nv0), 0);
    check("rw_dec_stop", 32'(dec_stop), 0);
`ifdef NOVA_BS_FEEDER_STATS_EN
    check("rw_stall", stall_cycles, 0);
    check("rw_words", words_in, 4);
`endif

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
